// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage feeding the IF/ID register.
// Holds the PC, issues one word fetch at a time over a req/gnt/rvalid port,
// buffers returned words in a small FIFO and presents them to decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch / bubble counters.
module if_fetch_stage #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0040_0000),
   parameter int unsigned           BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_stall,
   input  logic                  if_id_stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   output logic [31:0]           if_id_instr,
   output logic [ADDR_WIDTH-1:0] if_id_pc4,
   output logic                  if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_bubble_cnt
`endif
);

   localparam int unsigned           PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned           CNT_W      = PTR_W + 1;
   localparam int unsigned           ENT_W      = ADDR_WIDTH + 32;
   localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(32'd4);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(32'd3));
   localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(32'd1);
   localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(32'd1);

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_WAIT_RSP = 2'd1,
      ST_DRAIN    = 2'd2
   } state_e;

   state_e                 state_q;
   logic [ADDR_WIDTH-1:0]  pc_q;
   logic [ADDR_WIDTH-1:0]  req_pc_q;
   logic [ENT_W-1:0]       buf_q [BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_d;
   logic [31:0]            if_id_instr_q;
   logic [ADDR_WIDTH-1:0]  if_id_pc4_q;
   logic                   if_id_valid_q;

   logic                   req_s;
   logic                   fire_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   bubble_s;
   logic [ENT_W-1:0]       head_s;

   assign head_s      = buf_q[rd_ptr_q];
   assign imem_req    = req_s;
   assign imem_addr   = pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign if_id_valid = if_id_valid_q;

   // Request gating, buffer push/pop decisions and next occupancy.
   always_comb begin
      req_s    = 1'b0;
      fire_s   = 1'b0;
      push_s   = 1'b0;
      pop_s    = 1'b0;
      bubble_s = 1'b0;
      count_d  = count_q;
      // Only issue when idle, not redirected/stalled, and a slot is guaranteed.
      if (rst_n && (state_q == ST_FETCH) && !flush && !pc_stall && (count_q < DEPTH_C)) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
      fire_s   = req_s & imem_gnt;
      push_s   = (state_q == ST_WAIT_RSP) & imem_rvalid & ~flush;
      pop_s    = ~flush & ~if_id_stall & (count_q != CNT_ZERO);
      bubble_s = ~flush & ~if_id_stall & (count_q == CNT_ZERO);
      if (flush) begin
         count_d = CNT_ZERO;
      end else if (push_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Fetch FSM and PC: one request in flight, flush redirects and squashes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else if (flush) begin
         pc_q <= branch_target & ALIGN_MASK;
         case (state_q)
            ST_FETCH:    state_q <= ST_FETCH;
            ST_WAIT_RSP: state_q <= imem_rvalid ? ST_FETCH : ST_DRAIN;
            ST_DRAIN:    state_q <= imem_rvalid ? ST_FETCH : ST_DRAIN;
            default:     state_q <= ST_FETCH;
         endcase
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (fire_s) begin
                  req_pc_q <= pc_q;
                  pc_q     <= pc_q + PC_INC;
                  state_q  <= ST_WAIT_RSP;
               end
            end
            ST_WAIT_RSP: begin
               if (imem_rvalid) begin
                  state_q <= ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (imem_rvalid) begin
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

   // Fetch buffer: circular FIFO of {pc+4, instruction}, cleared on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= {ENT_W{1'b0}};
         end
         rd_ptr_q <= PTR_ZERO;
         wr_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         count_q <= count_d;
         if (flush) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
         end else begin
            if (push_s) begin
               buf_q[wr_ptr_q] <= {req_pc_q + PC_INC, imem_rdata};
               wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
         end
      end
   end

   // IF/ID register: load buffer head or a bubble; flush forces a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_instr_q <= 32'd0;
         if_id_pc4_q   <= {ADDR_WIDTH{1'b0}};
         if_id_valid_q <= 1'b0;
      end else if (flush) begin
         if_id_instr_q <= 32'd0;
         if_id_valid_q <= 1'b0;
      end else if (!if_id_stall) begin
         if (pop_s) begin
            if_id_instr_q <= head_s[31:0];
            if_id_pc4_q   <= head_s[ENT_W-1:32];
            if_id_valid_q <= 1'b1;
         end else begin
            if_id_instr_q <= 32'd0;
            if_id_valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_bubble_q;

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_bubble_cnt = perf_bubble_q;

   // Free-running event counters: accepted responses and non-flush bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q  <= 32'd0;
         perf_bubble_q <= 32'd0;
      end else begin
         if (push_s) begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
         if (bubble_s) begin
            perf_bubble_q <= perf_bubble_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a long
// randomized run, all checked against a queue-based reference model.
module tb_if_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          DEPTH    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, pc_stall, if_id_stall, flush, imem_gnt, imem_rvalid;
   logic [31:0] branch_target, imem_addr, imem_rdata, if_id_instr, if_id_pc4;
   logic        imem_req, if_id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   if_fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .flush(flush), .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   bit rv_en, rv_force;

   // Reference model: PC, one outstanding slot (live or squashed), word queue, IF/ID.
   logic [31:0] mpc, m_oaddr, m_instr, m_pc4;
   bit          m_out, m_live, m_valid;
   logic [63:0] bufq[$];
   int unsigned m_fetches, m_bubbles;
   bit          e_req;
   logic [31:0] e_addr;
   logic        s_req;
   logic [31:0] s_addr;

   task automatic model_reset();
      mpc = RESET_PC; m_oaddr = 32'd0; m_out = 1'b0; m_live = 1'b0;
      bufq.delete(); m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_fetches = 0; m_bubbles = 0;
   endtask

   // One clock: drive responder, sample request mid-cycle, advance model, settle.
   task automatic tick();
      bit g, resp;
      imem_rvalid = (rv_en && m_out) || rv_force;
      imem_rdata  = $urandom();
      @(negedge clk);
      s_req  = imem_req;
      s_addr = imem_addr;
      e_req  = rst_n && !flush && !pc_stall && !m_out && (bufq.size() < DEPTH);
      e_addr = mpc;
      g      = e_req && imem_gnt;
      resp   = m_out && imem_rvalid;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         mpc = branch_target & 32'hFFFF_FFFC;
         bufq.delete();
         m_instr = 32'd0; m_valid = 1'b0;
         if (resp) m_out = 1'b0; else m_live = 1'b0;
      end else begin
         if (!if_id_stall) begin
            if (bufq.size() > 0) begin
               {m_pc4, m_instr} = bufq.pop_front();
               m_valid = 1'b1;
            end else begin
               m_instr = 32'd0; m_valid = 1'b0; m_bubbles++;
            end
         end
         if (resp) begin
            if (m_live) begin
               bufq.push_back({m_oaddr + 32'd4, imem_rdata});
               m_fetches++;
            end
            m_out = 1'b0;
         end
         if (g) begin
            m_out = 1'b1; m_live = 1'b1; m_oaddr = mpc; mpc = mpc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_stall = 1'b0; if_id_stall = 1'b0; flush = 1'b0;
      branch_target = 32'd0; imem_gnt = 1'b1; rv_en = 1'b0; rv_force = 1'b0;
      model_reset();
      tick(); tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", s_req); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
      checks++; if (if_id_pc4 !== 32'd0) begin errors++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
      // Reset in the middle of a transaction, then a stale response arrives.
      rst_n = 1'b1; tick();
      checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL first_req: got %b/%h want 1/%h", s_req, s_addr, RESET_PC); end
      rst_n = 1'b0; model_reset(); imem_gnt = 1'b0; tick();
      rst_n = 1'b1; rv_force = 1'b1; tick(); rv_force = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL late_rvalid_req: got %b/%h want 1/%h", s_req, s_addr, RESET_PC); end
         checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL late_rvalid_valid: got %b want 0", if_id_valid); end
      end
   endtask

   task automatic test_sequential();
      logic [31:0] gq[$];
      int first_valid = -1;
      logic [31:0] first_pc4 = 32'd0;
      imem_gnt = 1'b1; rv_en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++; if (s_req !== e_req) begin errors++; $display("FAIL seq_req: got %b want %b", s_req, e_req); end
         if (s_req === 1'b1) gq.push_back(s_addr);
         checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL seq_valid: got %b want %b", if_id_valid, m_valid); end
         if (if_id_valid === 1'b1 && first_valid < 0) begin first_valid = c; first_pc4 = if_id_pc4; end
      end
      checks++;
      if (gq.size() < 3) begin errors++; $display("FAIL seq_grants: got %0d want >=3", gq.size()); end
      else if (gq[0] !== 32'h0040_0000 || gq[1] !== 32'h0040_0004 || gq[2] !== 32'h0040_0008) begin
         errors++; $display("FAIL seq_addrs: got %h %h %h want 00400000 00400004 00400008", gq[0], gq[1], gq[2]);
      end
      checks++; if (first_valid != 2) begin errors++; $display("FAIL seq_latency: got %0d want 2", first_valid); end
      checks++; if (first_pc4 !== 32'h0040_0004) begin errors++; $display("FAIL seq_first_pc4: got %h want 00400004", first_pc4); end
   endtask

   task automatic test_load_use();
      logic [31:0] h_instr, h_pc4, prev;
      int n = 0;
      imem_gnt = 1'b1; rv_en = 1'b1;
      while (if_id_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL lu_timeout: got %b want 1", if_id_valid); end
      h_instr = if_id_instr; h_pc4 = if_id_pc4;
      pc_stall = 1'b1; if_id_stall = 1'b1; tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL lu_req: got %b want 0", s_req); end
      checks++; if (if_id_instr !== h_instr || if_id_pc4 !== h_pc4 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL lu_hold: got %h/%h/%b want %h/%h/1", if_id_instr, if_id_pc4, if_id_valid, h_instr, h_pc4);
      end
      pc_stall = 1'b0; if_id_stall = 1'b0; prev = h_pc4;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL lu_valid: got %b want %b", if_id_valid, m_valid); end
         if (if_id_valid === 1'b1) begin
            checks++; if (if_id_pc4 !== prev + 32'd4 || if_id_instr !== m_instr) begin
               errors++; $display("FAIL lu_seq: got %h/%h want %h/%h", if_id_pc4, if_id_instr, prev + 32'd4, m_instr);
            end
            prev = if_id_pc4;
         end
      end
   endtask

   task automatic test_stall_fill();
      logic       h_valid;
      logic [31:0] h_pc4, p1;
      imem_gnt = 1'b1; rv_en = 1'b1; if_id_stall = 1'b1;
      h_valid = if_id_valid; h_pc4 = if_id_pc4;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (if_id_valid !== h_valid || if_id_pc4 !== h_pc4) begin
            errors++; $display("FAIL fill_hold: got %b/%h want %b/%h", if_id_valid, if_id_pc4, h_valid, h_pc4);
         end
      end
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL fill_req: got %b want 0", s_req); end
      if_id_stall = 1'b0; imem_gnt = 1'b0;
      tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL fill_req_full: got %b want 0", s_req); end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== m_pc4) begin errors++; $display("FAIL drain1: got %b/%h want 1/%h", if_id_valid, if_id_pc4, m_pc4); end
      p1 = if_id_pc4;
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== p1 + 32'd4) begin errors++; $display("FAIL drain2: got %b/%h want 1/%h", if_id_valid, if_id_pc4, p1 + 32'd4); end
      tick();
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", if_id_valid); end
   endtask

   task automatic test_flush_wait();
      int n = 0;
      imem_gnt = 1'b1; rv_en = 1'b0;
      while (!(m_out && m_live) && n < 10) begin tick(); n++; end
      checks++; if (!(m_out && m_live)) begin errors++; $display("FAIL fw_timeout: got %b want 1", m_out); end
      flush = 1'b1; branch_target = 32'h0040_0100; tick();
      checks++; if (s_req !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL fw_flush: got %b/%b want 0/0", s_req, if_id_valid); end
      flush = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (s_req !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL fw_drain: got %b/%b want 0/0", s_req, if_id_valid); end
      end
      rv_en = 1'b1; tick();
      checks++; if (s_req !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL fw_drop: got %b/%b want 0/0", s_req, if_id_valid); end
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h0040_0100) begin errors++; $display("FAIL fw_addr: got %b/%h want 1/00400100", s_req, s_addr); end
      n = 0;
      while (if_id_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0040_0104) begin errors++; $display("FAIL fw_pc4: got %b/%h want 1/00400104", if_id_valid, if_id_pc4); end
   endtask

   task automatic test_flush_rvalid();
      int n = 0;
      imem_gnt = 1'b1; rv_en = 1'b0;
      while (!(m_out && m_live) && n < 10) begin tick(); n++; end
      checks++; if (!(m_out && m_live)) begin errors++; $display("FAIL fr_timeout: got %b want 1", m_out); end
      flush = 1'b1; branch_target = 32'h0040_0200; rv_en = 1'b1; tick();
      flush = 1'b0; rv_en = 1'b0; tick();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h0040_0200) begin errors++; $display("FAIL fr_fetch: got %b/%h want 1/00400200", s_req, s_addr); end
      rv_en = 1'b1; n = 0;
      while (if_id_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0040_0204) begin errors++; $display("FAIL fr_pc4: got %b/%h want 1/00400204", if_id_valid, if_id_pc4); end
   endtask

   task automatic test_wrap();
      int n = 0;
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] f0;
`endif
      imem_gnt = 1'b0; rv_en = 1'b1;
      while (m_out && n < 10) begin tick(); n++; end
      flush = 1'b1; branch_target = 32'hFFFF_FFFC; imem_gnt = 1'b1; tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL wrap_gated: got %b want 0", s_req); end
      flush = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      f0 = perf_fetch_cnt;
`endif
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %b/%h want 1/fffffffc", s_req, s_addr); end
      tick();
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_fetch_cnt - f0 !== 32'd1) begin errors++; $display("FAIL wrap_perf: got %0d want 1", perf_fetch_cnt - f0); end
`endif
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next: got %b/%h want 1/00000000", s_req, s_addr); end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0000_0000 || if_id_instr !== m_instr) begin
         errors++; $display("FAIL wrap_pc4: got %b/%h/%h want 1/00000000/%h", if_id_valid, if_id_pc4, if_id_instr, m_instr);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         pc_stall    = ($urandom_range(0, 99) < 15);
         if_id_stall = ($urandom_range(0, 99) < 25);
         flush       = ($urandom_range(0, 99) < 5);
         branch_target = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                     : (RESET_PC + $urandom_range(0, 4095));
         imem_gnt = ($urandom_range(0, 99) < 60);
         rv_en    = ($urandom_range(0, 99) < 50);
         tick();
         checks++; if (s_req !== e_req) begin errors++; $display("FAIL rnd_req: got %b want %b", s_req, e_req); end
         if (e_req) begin
            checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_addr: got %h want %h", s_addr, e_addr); end
         end
         checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", if_id_valid, m_valid); end
         if (m_valid) begin
            checks++; if (if_id_pc4 !== m_pc4 || if_id_instr !== m_instr) begin
               errors++; $display("FAIL rnd_data: got %h/%h want %h/%h", if_id_pc4, if_id_instr, m_pc4, m_instr);
            end
         end else begin
            checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL rnd_bubble: got %h want 0", if_id_instr); end
         end
      end
      pc_stall = 1'b0; if_id_stall = 1'b0; flush = 1'b0; imem_gnt = 1'b0; rv_en = 1'b1;
      for (int c = 0; c < 8; c++) tick();
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_fetch_cnt !== m_fetches) begin errors++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, m_fetches); end
      checks++; if (perf_bubble_cnt !== m_bubbles) begin errors++; $display("FAIL perf_bubble: got %0d want %0d", perf_bubble_cnt, m_bubbles); end
`endif
   endtask

   initial begin
      rst_n = 1'b0; pc_stall = 1'b0; if_id_stall = 1'b0; flush = 1'b0;
      branch_target = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      rv_en = 1'b0; rv_force = 1'b0;
      test_reset();
      test_sequential();
      test_load_use();
      test_stall_fill();
      test_flush_wait();
      test_flush_rvalid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
